// File: rtl/riscv_decode.sv
// riscv_decode: decodes OP/OP-IMM/LUI/AUIPC into an ALU op/operand triple behind a 1-cycle output register.
// Valid/ready output: a stall holds every output stable, flush drops the held op, accept and consume may overlap.
module riscv_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        illegal_o,
  output logic [15:0] illegal_cnt_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_AND  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SRL  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_ONE  = 4'd6;
  localparam logic [3:0] ALU_ZERO = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_LUI  = 4'd9;
  localparam logic [3:0] ALU_SUB  = 4'd10;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } dec_t;

  dec_t        dec;
  dec_t        res_q, res_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_u, opnd_b;
  logic [4:0]  shamt;
  logic        is_op, f7_ok, legal;
  logic [3:0]  op;
  logic [31:0] a, b;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'h000};
  assign is_op  = (opcode == OPC_OP);
  assign opnd_b = is_op ? rs2_data_i : imm_i;
  assign shamt  = is_op ? rs2_data_i[4:0] : instr_i[24:20];
  assign f7_ok  = (funct7 == 7'b0000000) ||
                  ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  always_comb begin
    legal = 1'b0;
    op    = ALU_ADD;
    a     = rs1_data_i;
    b     = opnd_b;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        // OP-IMM only polices funct7 on the shift encodings
        legal = (is_op || (funct3 == 3'b001) || (funct3 == 3'b101)) ? f7_ok : 1'b1;
        case (funct3)
          3'b000:  op = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  begin op = ALU_SLL; b = {27'd0, shamt}; end
          3'b101:  begin op = funct7[5] ? ALU_SRA : ALU_SRL; b = {27'd0, shamt}; end
          3'b100:  op = ALU_XOR;
          3'b110:  op = ALU_OR;
          3'b111:  op = ALU_AND;
          3'b010:  op = ($signed(rs1_data_i) < $signed(opnd_b)) ? ALU_ONE : ALU_ZERO;
          default: op = (rs1_data_i < opnd_b) ? ALU_ONE : ALU_ZERO;
        endcase
      end
      OPC_LUI: begin
        legal = 1'b1;
        op    = ALU_LUI;
        a     = 32'd0;
        b     = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        op    = ALU_ADD;
        a     = pc_i;
        b     = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    dec = '0;
    if (legal) begin
      dec.op    = op;
      dec.a     = a;
      dec.b     = b;
      dec.rd    = instr_i[11:7];
      dec.rd_we = |instr_i[11:7];
    end else begin
      dec.op      = ALU_ZERO;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready_o = !flush_i && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      res_d       = dec;
      if (dec.illegal && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cnt_q       <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign alu_op_o      = res_q.op;
  assign alu_a_o       = res_q.a;
  assign alu_b_o       = res_q.b;
  assign rd_o          = res_q.rd;
  assign rd_we_o       = res_q.rd_we;
  assign illegal_o     = res_q.illegal;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_decode.sv
// Bench for riscv_decode: random and directed bundles, scoreboard fed at accept, monitor compares on every output cycle.
module tb_riscv_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [4:0]  rd_o;
  logic        rd_we_o;
  logic        illegal_o;
  logic [15:0] illegal_cnt_o;

  riscv_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .instr_i      (instr_i),
    .pc_i         (pc_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .flush_i      (flush_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .alu_op_o     (alu_op_o),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .rd_o         (rd_o),
    .rd_we_o      (rd_we_o),
    .illegal_o    (illegal_o),
    .illegal_cnt_o(illegal_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic        exp_rdy = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  localparam logic [31:0] I_ADD   = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
  localparam logic [31:0] I_SLTI  = {12'hFFF, 5'd1, 3'd2, 5'd4, 7'h13};
  localparam logic [31:0] I_SLTIU = {12'hFFF, 5'd1, 3'd3, 5'd4, 7'h13};
  localparam logic [31:0] I_AUIPC = {20'h12345, 5'd5, 7'h17};
  localparam logic [31:0] I_LUI   = {20'hABCDE, 5'd0, 7'h37};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [6:0]  opc = ins[6:0];
    logic [2:0]  f3  = ins[14:12];
    logic [6:0]  f7  = ins[31:25];
    logic [31:0] imm = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] src2;
    longint      s1, s2;
    bit          good_f7, legal;
    e.op = 4'd0; e.a = 32'd0; e.b = 32'd0; e.rd = 5'd0; e.we = 1'b0; e.ill = 1'b0;
    legal   = 1'b0;
    good_f7 = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (opc == 7'h37) begin
      legal = 1'b1; e.op = 4'd9; e.b = {ins[31:12], 12'h000};
    end else if (opc == 7'h17) begin
      legal = 1'b1; e.op = 4'd0; e.a = pc; e.b = {ins[31:12], 12'h000};
    end else if (opc == 7'h33 || opc == 7'h13) begin
      legal = (opc == 7'h33 || f3 == 3'd1 || f3 == 3'd5) ? good_f7 : 1'b1;
      src2  = (opc == 7'h33) ? r2 : imm;
      e.a   = r1;
      e.b   = src2;
      s1    = longint'($signed(r1));
      s2    = longint'($signed(src2));
      case (f3)
        3'd0: e.op = (opc == 7'h33 && f7 == 7'h20) ? 4'd10 : 4'd0;
        3'd1: begin e.op = 4'd2; e.b = src2 & 32'h1F; end
        3'd2: e.op = (s1 < s2) ? 4'd6 : 4'd7;
        3'd3: e.op = (r1 < src2) ? 4'd6 : 4'd7;
        3'd4: e.op = 4'd5;
        3'd5: begin e.op = (f7 == 7'h20) ? 4'd8 : 4'd3; e.b = src2 & 32'h1F; end
        3'd6: e.op = 4'd4;
        default: e.op = 4'd1;
      endcase
    end
    if (legal) begin
      e.rd = ins[11:7]; e.we = (ins[11:7] != 5'd0); e.ill = 1'b0;
    end else begin
      e.op = 4'd7; e.a = 32'd0; e.b = 32'd0; e.rd = 5'd0; e.we = 1'b0; e.ill = 1'b1;
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: whatever the handshake accepts is predicted here.
  always @(posedge clk) begin
    exp_t e;
    if (rst_n && in_valid_i && exp_rdy) begin
      e = ref_decode(instr_i, pc_i, rs1_data_i, rs2_data_i);
      sb.push_back(e);
      if (e.ill && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  // Monitor: compares the held output every cycle and retires it on consume or flush.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rdy = 1'b0;
    end else begin
      exp_rdy = !flush_i && (sb.size() == 0 || out_ready_i);
      chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid_o), 32'(sb.size() != 0));
      chk("illegal_cnt", 32'(illegal_cnt_o), 32'(m_cnt));
      if (sb.size() != 0) begin
        chk("alu_op", 32'(alu_op_o), 32'(sb[0].op));
        chk("alu_a", alu_a_o, sb[0].a);
        chk("alu_b", alu_b_o, sb[0].b);
        chk("rd", 32'(rd_o), 32'(sb[0].rd));
        chk("rd_we", 32'(rd_we_o), 32'(sb[0].we));
        chk("illegal", 32'(illegal_o), 32'(sb[0].ill));
        if (out_ready_i || flush_i) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid_i = v; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    out_ready_i = ordy; flush_i = fl;
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  f7;
    int          k = $urandom_range(0, 9);
    case ($urandom_range(0, 3))
      0, 2: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (k <= 3) begin
      w[6:0] = 7'h33; w[31:25] = f7;
    end else if (k <= 6) begin
      w[6:0] = 7'h13;
      if ($urandom_range(0, 1) == 1) w[31:25] = f7;
    end else if (k == 7) begin
      w[6:0] = 7'h37;
    end else if (k == 8) begin
      w[6:0] = 7'h17;
    end
    return w;
  endfunction

  task automatic drive_rand();
    logic [31:0] r1 = rand_data();
    logic [31:0] r2 = ($urandom_range(0, 7) == 0) ? r1 : rand_data();
    drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, r1, r2,
          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op_o), 32'd0);
    chk({tag, "_alu_a"}, alu_a_o, 32'd0);
    chk({tag, "_alu_b"}, alu_b_o, 32'd0);
    chk({tag, "_rd"}, 32'(rd_o), 32'd0);
    chk({tag, "_rd_we"}, 32'(rd_we_o), 32'd0);
    chk({tag, "_illegal"}, 32'(illegal_o), 32'd0);
    chk({tag, "_illegal_cnt"}, 32'(illegal_cnt_o), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
      n++;
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d outputs still pending, expected 0 after drain budget", tag, sb.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid_i = 1'b0; instr_i = 32'd0; pc_i = 32'd0;
    rs1_data_i = 32'd0; rs2_data_i = 32'd0; flush_i = 1'b0; out_ready_i = 1'b0;
    #12;
    check_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check_zero("post_reset");

    // Directed decode with out_ready high: one result per cycle.
    drive(1'b1, I_ADD, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
    drive(1'b1, I_SLTI, 32'h4, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("add_valid", 32'(out_valid_o), 32'd1);
    chk("add_op", 32'(alu_op_o), 32'd0);
    chk("add_a", alu_a_o, 32'd5);
    chk("add_b", alu_b_o, 32'd7);
    chk("add_rd", 32'(rd_o), 32'd3);
    chk("add_rd_we", 32'(rd_we_o), 32'd1);
    drive(1'b1, I_SLTIU, 32'h8, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("slti_op", 32'(alu_op_o), 32'd6);
    drive(1'b1, I_AUIPC, 32'h100, $urandom, $urandom, 1'b1, 1'b0);
    @(negedge clk);
    chk("sltiu_op", 32'(alu_op_o), 32'd7);
    drive(1'b1, I_LUI, 32'h104, $urandom, $urandom, 1'b1, 1'b0);
    @(negedge clk);
    chk("auipc_op", 32'(alu_op_o), 32'd0);
    chk("auipc_a", alu_a_o, 32'h100);
    chk("auipc_b", alu_b_o, 32'h1234_5000);
    chk("auipc_rd", 32'(rd_o), 32'd5);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("lui_op", 32'(alu_op_o), 32'd9);
    chk("lui_a", alu_a_o, 32'd0);
    chk("lui_b", alu_b_o, 32'hABCD_E000);
    chk("lui_rd_we", 32'(rd_we_o), 32'd0);

    // Back-pressure for three cycles with a bundle waiting.
    drive(1'b1, I_ADD, 32'h0, 32'd11, 32'd22, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, I_SLTI, 32'h0, 32'd33, 32'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready_o), 32'd0);
      chk("bp_hold_a", alu_a_o, 32'd11);
    end
    drive(1'b1, I_SLTI, 32'h0, 32'd33, 32'd0, 1'b1, 1'b0);
    drive(1'b1, I_AUIPC, 32'h200, 32'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Flush a stalled output while an illegal bundle is offered.
    drive(1'b1, I_ADD, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0000, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready_o), 32'd0);
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid_o), 32'd0);

    repeat (3000) drive_rand();
    drain("drain_random");

    // Drive the illegal counter into saturation.
    repeat (32'h10000) drive(1'b1, 32'h0000_0000, 32'd0, $urandom, $urandom, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    drain("drain_saturate");
    chk("cnt_saturated", 32'(illegal_cnt_o), 32'h0000_FFFF);

    // Asynchronous reset while an output is stalled.
    drive(1'b1, I_ADD, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
    drive(1'b1, I_SLTI, 32'h0, 32'd9, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    m_cnt = 16'd0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    #1;
    check_zero("mid_reset");
    @(posedge clk); #1; rst_n = 1'b1;

    repeat (300) drive_rand();
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
